stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Run-controlled three-digit BCD stopwatch (M:SS, 0:00–9:59) between the 50 MHz board clock and the per-digit seven-segment decoders. Divides CLOCK_50 into a one-second tick internally and advances a seconds/minutes BCD cascade only while running. Start/stop and clear commands come from a debounced pushbutton stage. Each 4-bit digit output drives one HEX decoder directly.

## Interface
- TICK_DIV, 50000000: CLOCK_50 cycles per count tick; minimum 2.
- CLOCK_50  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_stop  in  1  single-cycle pulse; toggles run/pause, or starts from idle.
- clear  in  1  single-cycle pulse; returns to idle with all digits zeroed.
- lap  in  1  single-cycle pulse; toggles display freeze (LAP_EN only; ignored otherwise).
- sec_ones  out  4  displayed seconds units, BCD 0–9.
- sec_tens  out  4  displayed seconds tens, BCD 0–5.
- min_ones  out  4  displayed minutes, BCD 0–9.
- running  out  1  high while state is RUN.
- wrap  out  1  one-cycle pulse when the count rolls 9:59 -> 0:00.
- lap_active  out  1  high while the display is frozen; constant 0 without LAP_EN.

## Operation
- Reset (resetn low, asynchronous): state IDLE, all digits 0, divider 0, running/wrap/lap_active 0.
- States:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - clear in any state -> IDLE.
- clear has priority over start_stop and lap in the same cycle.
- Divider: counts 0..TICK_DIV-1 only in RUN and holds in PAUSE, so a partial second is preserved.
  - clear and reset zero the divider.
  - tick is high for one cycle when the divider = TICK_DIV-1 in RUN; the divider then returns to 0.
- Cascade on tick:
  - sec_ones increments; 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 with a carry in asserts wrap.
- No invalid BCD value is ever produced. Counting continues after wrap; no saturation.
- Divider width: $clog2(TICK_DIV) bits.

## Timing
- start_stop in IDLE at cycle n: running high from n+1.
- First tick at cycle n+TICK_DIV; digits update at n+TICK_DIV+1.
- Digit outputs are registered: each update is visible one cycle after the tick cycle.
- wrap is high in the same cycle the digits first read 0:00.
- clear at cycle n: digits read 0, running is 0, and lap_active is 0 from n+1.
- A tick and start_stop in the same RUN cycle: the increment still happens, then the state enters PAUSE.
- Reset asserted mid-count: outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- STOPWATCH_LAP_EN defined:
  - lap in RUN or PAUSE toggles lap_active.
  - While lap_active is high, the outputs hold a snapshot taken in the cycle lap was sampled; the internal count continues.
  - Releasing the freeze shows the live count from the next cycle.
  - lap in IDLE is ignored. Pausing does not release the freeze; clear does.
- STOPWATCH_LAP_EN undefined:
  - The lap input is unused and lap_active is tied to 0.
  - Digit outputs always show the live count; no snapshot registers exist.

## Structure
- Package stopwatch_pkg holds:
  - state encoding (IDLE, RUN, PAUSE);
  - digit limit constants: SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9.
- One sub-module, tick_divider: parameter TICK_DIV; ports CLOCK_50, resetn, en, clr, tick.
- The FSM, BCD cascade and lap snapshot stay in stopwatch_counter.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: resetn low mid-run -> all outputs 0 immediately. Release, then start_stop -> running=1 next cycle; first digit change (0:01) 5 cycles after the pulse.
- Full cascade: run 599 ticks -> 9:59. Next tick -> 0:00 with wrap high for exactly one cycle. Check sec_tens never exceeds 5 and no digit exceeds 9.
- Pause preservation: pause 2 cycles into a tick period, hold 20 cycles, resume. The next increment comes 2 cycles after resume and digits stay constant while paused.
- Clear priority: clear and start_stop in the same cycle while in RUN at 3:27 -> IDLE, 0:00, running=0. The divider restarts from 0 on the next start.
- Lap (STOPWATCH_LAP_EN): lap at 0:12 -> outputs hold 0:12 and lap_active=1 while the internal count reaches 0:20. Second lap -> outputs show 0:20 the next cycle.
- Without STOPWATCH_LAP_EN: lap pulses in RUN -> lap_active stays 0 and digits track the live count.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//
// Shared definitions for the M:SS stopwatch:
//   state_t      - run-control states (IDLE, RUN, PAUSE)
//   digits_t     - the three BCD digits of the count, minutes in the MSBs
//   *_MAX        - highest legal value of each digit before it rolls to 0
//   bcd_step()   - advances one BCD digit by an incoming carry and reports
//                  the carry out to the next digit
// ---------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] SEC_ONES_MAX = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] MIN_ONES_MAX = 4'd9;

   typedef struct packed {
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } digits_t;

   // Returns {carry_out, next_digit}. The >= comparison folds any
   // out-of-range value back to 0 so a digit can never stick above its limit.
   function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                           input logic [3:0] max_val,
                                           input logic       carry_in);
      logic [4:0] result;
      if (!carry_in) begin
         result = {1'b0, digit};
      end else if (digit >= max_val) begin
         result = {1'b1, 4'd0};
      end else begin
         result = {1'b0, digit + 4'd1};
      end
      return result;
   endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// ---------------------------------------------------------------------------
// stopwatch_counter_if
//
// Bundles the stopwatch command pulses and display outputs.
//   start_stop, clear, lap          - single-cycle command pulses (to stopwatch)
//   sec_ones, sec_tens, min_ones    - displayed BCD digits (from stopwatch)
//   running, wrap, lap_active       - status flags (from stopwatch)
// Modports:
//   master - the command source / display consumer
//   slave  - the stopwatch itself
// ---------------------------------------------------------------------------
interface stopwatch_counter_if;

   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic       running;
   logic       wrap;
   logic       lap_active;

   modport master (
      output start_stop, clear, lap,
      input  sec_ones, sec_tens, min_ones, running, wrap, lap_active
   );

   modport slave (
      input  start_stop, clear, lap,
      output sec_ones, sec_tens, min_ones, running, wrap, lap_active
   );

endinterface

// File: rtl/stopwatch_counter_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
//
// Divides CLOCK_50 down to a one-cycle tick every TICK_DIV enabled cycles.
// The count only advances while en is high and simply holds otherwise, so a
// partially elapsed period survives a pause.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   resetn   - asynchronous active-low reset, zeroes the count
//   en       - advance the count this cycle
//   clr      - synchronous zero of the count (wins over en)
//   tick     - high in the enabled cycle where the count is TICK_DIV-1
// Parameter:
//   TICK_DIV - cycles per tick, at least 2
// ---------------------------------------------------------------------------
module tick_divider #(
   parameter int TICK_DIV = 50000000
) (
   input  logic CLOCK_50,
   input  logic resetn,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The tick cycle itself reloads 0 so the period is exactly TICK_DIV cycles.
   always_comb begin
      tick  = en && (cnt_q == CNT_LAST);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//
// Run-controlled three-digit BCD stopwatch (M:SS, 0:00 to 9:59). A divider
// turns CLOCK_50 into a one-second tick while running; each tick advances a
// seconds/minutes BCD cascade that wraps 9:59 -> 0:00 with a one-cycle wrap
// pulse.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   resetn   - asynchronous active-low reset
//   sw       - stopwatch_counter_if.slave: start_stop/clear/lap command pulses
//              in; sec_ones/sec_tens/min_ones digits and running/wrap/
//              lap_active flags out
// Parameter:
//   TICK_DIV - CLOCK_50 cycles per count tick, at least 2
// Build option:
//   STOPWATCH_LAP_EN - when defined, lap toggles a display freeze that holds
//                      a snapshot while the live count keeps going. When not
//                      defined, lap is ignored and lap_active is 0.
// ---------------------------------------------------------------------------
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 50000000
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   stopwatch_counter_if.slave  sw
);

   state_t  state_q;
   state_t  state_d;
   digits_t count_q;
   digits_t count_d;
   logic    wrap_q;
   logic    wrap_d;
   logic    div_en;
   logic    tick;
   logic    running;
   digits_t disp;
   logic    lap_flag;

   // The divider only runs in RUN and is zeroed by clear so a fresh start
   // always waits a full period before the first increment.
   assign div_en = (state_q == ST_RUN);

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .en       (div_en),
      .clr      (sw.clear),
      .tick     (tick)
   );

   // State register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: clear beats everything, start_stop toggles run/pause.
   always_comb begin
      state_d = state_q;
      if (sw.clear) begin
         state_d = ST_IDLE;
      end else if (sw.start_stop) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      running = (state_q == ST_RUN);
   end

   // BCD cascade. A tick in the same cycle as start_stop still counts since
   // the tick is qualified only by the current state; clear wins over a tick.
   always_comb begin
      logic [4:0] ones_step;
      logic [4:0] tens_step;
      logic [4:0] mins_step;
      ones_step = 5'd0;
      tens_step = 5'd0;
      mins_step = 5'd0;
      count_d   = count_q;
      wrap_d    = 1'b0;
      if (sw.clear) begin
         count_d = '0;
      end else if (tick) begin
         ones_step        = bcd_step(count_q.sec_ones, SEC_ONES_MAX, 1'b1);
         tens_step        = bcd_step(count_q.sec_tens, SEC_TENS_MAX, ones_step[4]);
         mins_step        = bcd_step(count_q.min_ones, MIN_ONES_MAX, tens_step[4]);
         count_d.sec_ones = ones_step[3:0];
         count_d.sec_tens = tens_step[3:0];
         count_d.min_ones = mins_step[3:0];
         wrap_d           = mins_step[4];
      end
   end

   // Live count and wrap pulse; wrap lines up with the first 0:00 cycle.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef STOPWATCH_LAP_EN

   logic    lap_active_q;
   logic    lap_active_d;
   digits_t snap_q;
   digits_t snap_d;

   // Lap toggles the freeze outside IDLE. The snapshot captures what is on
   // the display in the lap cycle (the pre-tick value), and pausing leaves
   // the freeze alone; only clear or a second lap releases it.
   always_comb begin
      lap_active_d = lap_active_q;
      snap_d       = snap_q;
      if (sw.clear) begin
         lap_active_d = 1'b0;
      end else if (sw.lap && (state_q != ST_IDLE)) begin
         lap_active_d = !lap_active_q;
         if (!lap_active_q) begin
            snap_d = count_q;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         lap_active_q <= 1'b0;
         snap_q       <= '0;
      end else begin
         lap_active_q <= lap_active_d;
         snap_q       <= snap_d;
      end
   end

   assign disp     = lap_active_q ? snap_q : count_q;
   assign lap_flag = lap_active_q;

`else

   logic unused_lap;

   assign unused_lap = sw.lap;
   assign disp       = count_q;
   assign lap_flag   = 1'b0;

`endif

   assign sw.sec_ones   = disp.sec_ones;
   assign sw.sec_tens   = disp.sec_tens;
   assign sw.min_ones   = disp.min_ones;
   assign sw.running    = running;
   assign sw.wrap       = wrap_q;
   assign sw.lap_active = lap_flag;

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Self-checking bench for stopwatch_counter with TICK_DIV=4. A reference
// model tracks elapsed seconds as a plain integer (0..599) plus the number of
// running cycles into the current second, and derives the expected digits
// arithmetically. Scenario tasks run in sequence from one initial block.
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

   localparam int TICK_DIV = 4;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic CLOCK_50 = 1'b0;
   logic resetn;

   stopwatch_counter_if sw_if ();

   stopwatch_counter #(
      .TICK_DIV (TICK_DIV)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .sw       (sw_if)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int pass_count  = 0;
   int check_count = 0;

   // Reference model state
   bit m_active;
   bit m_running;
   bit m_lap;
   bit m_wrap;
   int m_phase;
   int m_secs;
   int m_snap;

   task automatic model_reset();
      m_active  = 1'b0;
      m_running = 1'b0;
      m_lap     = 1'b0;
      m_wrap    = 1'b0;
      m_phase   = 0;
      m_secs    = 0;
      m_snap    = 0;
   endtask

   task automatic model_update(input bit ss, input bit cl, input bit lp);
      m_wrap = 1'b0;
      if (cl) begin
         m_active  = 1'b0;
         m_running = 1'b0;
         m_lap     = 1'b0;
         m_phase   = 0;
         m_secs    = 0;
      end else begin
         if (LAP_EN && lp && m_active) begin
            if (!m_lap) m_snap = m_secs;
            m_lap = !m_lap;
         end
         if (m_running) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
               m_phase = 0;
               m_secs  = (m_secs + 1) % 600;
               m_wrap  = (m_secs == 0);
            end
         end
         if (ss) begin
            if (!m_active) begin
               m_active  = 1'b1;
               m_running = 1'b1;
            end else begin
               m_running = !m_running;
            end
         end
      end
   endtask

   // {sec_ones, sec_tens, min_ones, running, wrap, lap_active}
   function automatic logic [14:0] expected_out();
      int d;
      d = m_lap ? m_snap : m_secs;
      return {4'(d % 10), 4'((d / 10) % 6), 4'(d / 60), m_running, m_wrap, m_lap};
   endfunction

   function automatic logic [14:0] observed();
      return {sw_if.sec_ones, sw_if.sec_tens, sw_if.min_ones,
              sw_if.running, sw_if.wrap, sw_if.lap_active};
   endfunction

   // One clock cycle with the given command pulses; leaves time at edge+1.
   task automatic step(input bit ss, input bit cl, input bit lp);
      sw_if.start_stop = ss;
      sw_if.clear      = cl;
      sw_if.lap        = lp;
      @(posedge CLOCK_50);
      model_update(ss, cl, lp);
      #1;
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.lap        = 1'b0;
   endtask

   task automatic test_reset();
      logic [14:0] o;
      resetn           = 1'b0;
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.lap        = 1'b0;
      model_reset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      o = observed();
      check_count++;
      if (o !== 15'd0) $display("[TB] FAIL reset_initial: got %h expected %h", o, 15'd0);
      else pass_count++;
      #4 resetn = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b0);
      // assert reset between edges and look before any edge arrives
      #2 resetn = 1'b0;
      #1;
      model_reset();
      o = observed();
      check_count++;
      if (o !== 15'd0) $display("[TB] FAIL reset_async: got %h expected %h", o, 15'd0);
      else pass_count++;
      #1 resetn = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {12'd0, 1'b1, 1'b0, 1'b0}) $display("[TB] FAIL start_running: got %h expected %h", o, {12'd0, 3'b100});
      else pass_count++;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {12'd0, 3'b100}) $display("[TB] FAIL pre_first_tick: got %h expected %h", o, {12'd0, 3'b100});
      else pass_count++;
      step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {4'd1, 4'd0, 4'd0, 3'b100}) $display("[TB] FAIL first_tick: got %h expected %h", o, {4'd1, 4'd0, 4'd0, 3'b100});
      else pass_count++;
   endtask

   task automatic test_full_cascade();
      logic [14:0] o;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 599 * TICK_DIV; i++) begin
         step(1'b0, 1'b0, 1'b0);
         o = observed();
         check_count++;
         if (o !== expected_out()) $display("[TB] FAIL cascade: cycle %0d got %h expected %h", i, o, expected_out());
         else pass_count++;
         check_count++;
         if (o[14:11] > 4'd9 || o[10:7] > 4'd5 || o[6:3] > 4'd9)
            $display("[TB] FAIL bcd_range: cycle %0d got digits %h", i, o[14:3]);
         else pass_count++;
      end
      o = observed();
      check_count++;
      if (o[14:3] !== {4'd9, 4'd5, 4'd9}) $display("[TB] FAIL at_959: got %h expected %h", o[14:3], {4'd9, 4'd5, 4'd9});
      else pass_count++;
      repeat (TICK_DIV - 1) step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {4'd9, 4'd5, 4'd9, 3'b100}) $display("[TB] FAIL before_wrap: got %h expected %h", o, {4'd9, 4'd5, 4'd9, 3'b100});
      else pass_count++;
      step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {12'd0, 3'b110}) $display("[TB] FAIL wrap_rollover: got %h expected %h", o, {12'd0, 3'b110});
      else pass_count++;
      step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {12'd0, 3'b100}) $display("[TB] FAIL wrap_one_cycle: got %h expected %h", o, {12'd0, 3'b100});
      else pass_count++;
   endtask

   task automatic test_pause();
      logic [14:0] o;
      logic [11:0] held;
      int          guard;
      guard = 0;
      while (m_phase != 1 && guard < 10) begin
         step(1'b0, 1'b0, 1'b0);
         guard++;
      end
      check_count++;
      if (m_phase != 1) $display("[TB] FAIL pause_align: timeout got phase %0d expected 1", m_phase);
      else pass_count++;
      step(1'b1, 1'b0, 1'b0);
      o    = observed();
      held = o[14:3];
      check_count++;
      if (o !== expected_out()) $display("[TB] FAIL pause_enter: got %h expected %h", o, expected_out());
      else pass_count++;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0);
         o = observed();
         check_count++;
         if (o[14:3] !== held || o[2] !== 1'b0)
            $display("[TB] FAIL paused_hold: cycle %0d got %h expected %h running 0", i, o, held);
         else pass_count++;
      end
      step(1'b1, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o[14:3] !== held || o[2] !== 1'b1) $display("[TB] FAIL resume_no_jump: got %h expected %h running 1", o, held);
      else pass_count++;
      step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o[14:3] !== held) $display("[TB] FAIL resume_plus1: got %h expected %h", o[14:3], held);
      else pass_count++;
      step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o[14:3] === held || o !== expected_out()) $display("[TB] FAIL resume_plus2: got %h expected %h", o, expected_out());
      else pass_count++;
   endtask

   task automatic test_clear_priority();
      logic [14:0] o;
      int          guard;
      bit          reached;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      guard   = 0;
      reached = 1'b0;
      while (!reached && guard < 207 * TICK_DIV + 20) begin
         step(1'b0, 1'b0, 1'b0);
         o = observed();
         if (o !== expected_out()) begin
            check_count++;
            $display("[TB] FAIL run_to_327: got %h expected %h", o, expected_out());
         end
         reached = (o[14:3] === {4'd7, 4'd2, 4'd3});
         guard++;
      end
      check_count++;
      if (!reached) $display("[TB] FAIL reach_327: timeout got %h expected %h", o[14:3], {4'd7, 4'd2, 4'd3});
      else pass_count++;
      step(1'b1, 1'b1, 1'b0);
      o = observed();
      check_count++;
      if (o !== 15'd0) $display("[TB] FAIL clear_priority: got %h expected %h", o, 15'd0);
      else pass_count++;
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {12'd0, 3'b100}) $display("[TB] FAIL restart_pre_tick: got %h expected %h", o, {12'd0, 3'b100});
      else pass_count++;
      step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o !== {4'd1, 8'd0, 3'b100}) $display("[TB] FAIL restart_tick: got %h expected %h", o, {4'd1, 8'd0, 3'b100});
      else pass_count++;
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      logic [14:0] o;
      int          guard;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      guard = 0;
      while (m_secs != 12 && guard < 12 * TICK_DIV + 10) begin
         step(1'b0, 1'b0, 1'b0);
         guard++;
      end
      step(1'b0, 1'b0, 1'b1);
      o = observed();
      check_count++;
      if (o !== {4'd2, 4'd1, 4'd0, 3'b101}) $display("[TB] FAIL lap_freeze: got %h expected %h", o, {4'd2, 4'd1, 4'd0, 3'b101});
      else pass_count++;
      guard = 0;
      while (m_secs != 20 && guard < 8 * TICK_DIV + 10) begin
         step(1'b0, 1'b0, 1'b0);
         o = observed();
         check_count++;
         if (o[14:3] !== {4'd2, 4'd1, 4'd0} || o[0] !== 1'b1)
            $display("[TB] FAIL lap_hold: got %h expected %h lap_active 1", o, {4'd2, 4'd1, 4'd0});
         else pass_count++;
         guard++;
      end
      step(1'b0, 1'b0, 1'b1);
      o = observed();
      check_count++;
      if (o !== {4'd0, 4'd2, 4'd0, 3'b100}) $display("[TB] FAIL lap_release: got %h expected %h", o, {4'd0, 4'd2, 4'd0, 3'b100});
      else pass_count++;
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      repeat (6) step(1'b0, 1'b0, 1'b0);
      o = observed();
      check_count++;
      if (o[0] !== 1'b1 || o !== expected_out()) $display("[TB] FAIL lap_survives_pause: got %h expected %h", o, expected_out());
      else pass_count++;
      step(1'b0, 1'b1, 1'b0);
      o = observed();
      check_count++;
      if (o !== 15'd0) $display("[TB] FAIL lap_cleared: got %h expected %h", o, 15'd0);
      else pass_count++;
   endtask
`else
   task automatic test_no_lap();
      logic [14:0] o;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, ($urandom % 3) == 0);
         o = observed();
         check_count++;
         if (o[0] !== 1'b0 || o !== expected_out())
            $display("[TB] FAIL nolap_track: cycle %0d got %h expected %h", i, o, expected_out());
         else pass_count++;
      end
   endtask
`endif

   task automatic test_random();
      logic [14:0] o;
      bit          ss;
      bit          cl;
      bit          lp;
      for (int i = 0; i < 1500; i++) begin
         ss = ($urandom % 10) == 0;
         cl = ($urandom % 97) == 0;
         lp = ($urandom % 7) == 0;
         step(ss, cl, lp);
         o = observed();
         check_count++;
         if (o !== expected_out()) $display("[TB] FAIL random: cycle %0d got %h expected %h", i, o, expected_out());
         else pass_count++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_full_cascade();
      test_pause();
      test_clear_priority();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`else
      test_no_lap();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
